// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode seven-segment driver: per-frame snapshot of the
// display word, one digit per slot with a leading blank gap, and a blinking colon DP.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_DIV    = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] nums,
  input  logic        colon_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic [15:0]      FRAME_RST = 16'hAAAA;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      frame;
  logic [BLK_W-1:0] blk;
  logic             phase;

  logic [3:0] nibble_c;
  logic       blank_c;
  logic [6:0] seg_c;
  logic       dp_c;
  logic [3:0] an_c;

  // Bit 16 of the display word carries nothing for this display.
  logic unused_nums_msb;
  assign unused_nums_msb = nums[16];

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hB: s = 7'b0111111;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Slot counter, digit index and frame snapshot taken at the very end of digit 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= 2'd0;
      frame <= FRAME_RST;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
      if (idx == 2'd3) frame <= nums[15:0];
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Free-running colon blink timebase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk   <= '0;
      phase <= 1'b0;
    end else if (blk == BLK_LAST) begin
      blk   <= '0;
      phase <= ~phase;
    end else begin
      blk <= blk + BLK_W'(1);
    end
  end

  always_comb begin
    nibble_c = 4'h0;
    case (idx)
      2'd0: nibble_c = frame[3:0];
      2'd1: nibble_c = frame[7:4];
      2'd2: nibble_c = frame[11:8];
      2'd3: nibble_c = frame[15:12];
      default: nibble_c = 4'h0;
    endcase
  end

  // Next output values; the blank gap overrides everything to avoid ghosting.
  always_comb begin
    blank_c = (cnt < CNT_BLANK);
    an_c    = 4'hF;
    seg_c   = 7'h7F;
    dp_c    = 1'b1;
    if (!blank_c) begin
      an_c  = ~(4'b0001 << idx);
      seg_c = decode(nibble_c);
      dp_c  = ~(colon_en & phase & (idx == 2'd2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= seg_c;
      dp  <= dp_c;
      an  <= an_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed and random stimulus against a step-count
// reference model (slot, digit, frame and blink phase derived arithmetically).
module tb_seg7_scan_driver;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned BLINK_DIV    = 64;
  localparam int unsigned FRAME_LEN    = 4 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [16:0] nums;
  logic        colon_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  int unsigned s;
  logic [15:0] mframe;
  logic [6:0]  dec_tab [16];

  seg7_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .nums    (nums),
    .colon_en(colon_en),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [6:0] eseg, input logic edp,
                           input logic [3:0] ean);
    total++;
    assert (seg === eseg) else begin
      bad++;
      $error("FAIL %s seg got=%b exp=%b (s=%0d)", tag, seg, eseg, s);
    end
    total++;
    assert (an === ean) else begin
      bad++;
      $error("FAIL %s an got=%b exp=%b (s=%0d)", tag, an, ean, s);
    end
    total++;
    assert (dp === edp) else begin
      bad++;
      $error("FAIL %s dp got=%b exp=%b (s=%0d)", tag, dp, edp, s);
    end
    total++;
    assert ($countones(~an) <= 1) else begin
      bad++;
      $error("FAIL %s an_multi_hot got=%b exp=at_most_one_low", tag, an);
    end
  endtask

  // One clock: expected outputs follow from the step index before the edge.
  task automatic step(input string tag);
    int unsigned c, d, ph;
    logic [3:0] nib;
    logic [6:0] eseg;
    logic [3:0] ean;
    logic       edp;
    c   = s % SCAN_DIV;
    d   = (s / SCAN_DIV) % 4;
    ph  = (s / BLINK_DIV) % 2;
    nib = 4'((mframe >> (4 * d)) & 16'hF);
    if (c < BLANK_CYCLES) begin
      eseg = 7'h7F;
      ean  = 4'hF;
      edp  = 1'b1;
    end else begin
      eseg = dec_tab[nib];
      ean  = 4'hF;
      ean[d] = 1'b0;
      edp  = (colon_en && ph == 1 && d == 2) ? 1'b0 : 1'b1;
    end
    @(posedge clk);
    if (s % FRAME_LEN == FRAME_LEN - 1) mframe = nums[15:0];
    s++;
    #1;
    check_out(tag, eseg, edp, ean);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
    dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
    dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
    dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
    dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
    dec_tab[10] = 7'h7F;      dec_tab[11] = 7'b0111111;
    dec_tab[12] = 7'h7F;      dec_tab[13] = 7'h7F;
    dec_tab[14] = 7'h7F;      dec_tab[15] = 7'h7F;

    rst_n    = 1'b0;
    nums     = 17'h01234;
    colon_en = 1'b0;
    s        = 0;
    mframe   = 16'hAAAA;

    // Reset hold
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_hold", 7'h7F, 1'b1, 4'hF);
    rst_n = 1'b1;

    // Blank first frame, then 1234 frame
    run("first_frames", 2 * FRAME_LEN);

    // AAAA frame then BBB5 frame (dash/blank decode)
    nums = 17'h0AAAA;
    run("aaaa_frame", FRAME_LEN);
    nums = 17'h0BBB5;
    run("bbb5_frame", 2 * FRAME_LEN);

    // Mid-frame change must not tear
    nums = 17'h01234;
    run("load_1234", FRAME_LEN);
    run("tear_pre", SCAN_DIV + 2);
    nums = 17'h05678;
    run("tear_post", 2 * FRAME_LEN - SCAN_DIV - 2);

    // Colon blink, then colon disabled
    colon_en = 1'b1;
    run("colon_on", 256);
    colon_en = 1'b0;
    run("colon_off", 128);

    // Random words and random colon enable
    for (int f = 0; f < 8; f++) begin
      nums = 17'($urandom);
      for (int k = 0; k < FRAME_LEN; k++) begin
        colon_en = 1'($urandom_range(0, 1));
        step("random");
      end
    end

    // Asynchronous reset mid-slot at digit 2, cnt 5
    colon_en = 1'b1;
    nums     = 17'h19876;
    for (int g = 0; g < 4 * FRAME_LEN && (s % FRAME_LEN) != 2 * SCAN_DIV + 5; g++)
      step("seek_reset");
    total++;
    assert ((s % FRAME_LEN) == 2 * SCAN_DIV + 5) else begin
      bad++;
      $error("FAIL seek_reset pos got=%0d exp=%0d", s % FRAME_LEN, 2 * SCAN_DIV + 5);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 7'h7F, 1'b1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_held", 7'h7F, 1'b1, 4'hF);
    rst_n  = 1'b0;
    s      = 0;
    mframe = 16'hAAAA;
    nums   = 17'h01234;
    rst_n  = 1'b1;
    run("after_reset", 2 * FRAME_LEN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
